// File: rtl/load_store_buffer_pkg.sv
// Shared types and constants for the load/store buffer: ROB id width,
// funct3 width codes, IO address range and the queue entry layout.
package load_store_buffer_pkg;

  localparam int ROB_ID_W = 4;

  localparam logic [1:0] F3_BYTE = 2'd0;
  localparam logic [1:0] F3_HALF = 2'd1;
  localparam logic [1:0] F3_WORD = 2'd2;

  // Addresses whose bits [17:16] equal this base's bits are memory-mapped IO
  localparam logic [31:0] IO_BASE = 32'h0003_0000;

  typedef enum logic [1:0] {
    MEM_IDLE  = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic                valid;
    logic                store;
    logic                committed;
    logic [2:0]          funct3;
    logic [ROB_ID_W-1:0] rob_id;
    logic [31:0]         rs1_val;
    logic [31:0]         rs2_val;
    logic                rs1_rdy;
    logic                rs2_rdy;
    logic [ROB_ID_W-1:0] rs1_tag;
    logic [ROB_ID_W-1:0] rs2_tag;
    logic [31:0]         imm;
  } lsb_entry_t;

  function automatic logic [1:0] mem_width_of(input logic [1:0] size);
    case (size)
      F3_BYTE: return 2'd0;
      F3_HALF: return 2'd1;
      F3_WORD: return 2'd3;
      default: return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/lsb_load_ext.sv
// Sign/zero extension of raw load data according to the load's funct3.
module lsb_load_ext
  import load_store_buffer_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] data,
  output logic [31:0] ext
);

  always_comb begin
    ext = data;
    case (funct3[1:0])
      F3_BYTE: ext = funct3[2] ? {24'b0, data[7:0]} : {{24{data[7]}}, data[7:0]};
      F3_HALF: ext = funct3[2] ? {16'b0, data[15:0]} : {{16{data[15]}}, data[15:0]};
      F3_WORD: ext = data;
      default: ext = data;
    endcase
  end

endmodule

// File: rtl/load_store_buffer.sv
// In-order load/store queue feeding a single-request memory controller.
// Define LSB_SPEC_LOAD_EN to let non-IO loads issue before reaching the ROB head.
module load_store_buffer
  import load_store_buffer_pkg::*;
#(
  parameter int LSB_SIZE = 16
) (
  input  logic                clk,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic                roll_back,
  input  logic                issue_en,
  input  logic                issue_store,
  input  logic [2:0]          issue_funct3,
  input  logic [ROB_ID_W-1:0] issue_rob_id,
  input  logic [31:0]         issue_imm,
  input  logic [31:0]         issue_rs1_val,
  input  logic [31:0]         issue_rs2_val,
  input  logic                issue_rs1_rdy,
  input  logic                issue_rs2_rdy,
  input  logic [ROB_ID_W-1:0] issue_rs1_tag,
  input  logic [ROB_ID_W-1:0] issue_rs2_tag,
  input  logic                cdb_en,
  input  logic [ROB_ID_W-1:0] cdb_rob_id,
  input  logic [31:0]         cdb_val,
  input  logic [ROB_ID_W-1:0] rob_head_id,
  input  logic                commit_en,
  input  logic [ROB_ID_W-1:0] commit_rob_id,
  output logic                mem_req_en,
  output logic                mem_rw,
  output logic [1:0]          mem_width,
  output logic [31:0]         mem_ain,
  output logic [31:0]         mem_din,
  input  logic                mem_done,
  input  logic [31:0]         mem_dout,
  output logic                res_en,
  output logic [ROB_ID_W-1:0] res_rob_id,
  output logic [31:0]         res_val,
  output logic                lsb_full,
  output logic [1:0]          lsb_state
);

  localparam int PTR_W = $clog2(LSB_SIZE);
  localparam int CNT_W = PTR_W + 1;
`ifdef LSB_SPEC_LOAD_EN
  localparam logic SPEC_LOAD = 1'b1;
`else
  localparam logic SPEC_LOAD = 1'b0;
`endif

  lsb_entry_t       entries [LSB_SIZE];
  logic [PTR_W-1:0] head, tail, head_next;
  logic [CNT_W-1:0] count, next_count, committed_cnt;
  mem_state_t       state;

  lsb_entry_t  head_e, new_entry;
  logic [31:0] head_addr, load_ext;
  logic        is_io, head_ready, can_issue, pop, push;

  assign head_e    = entries[head];
  assign head_addr = head_e.rs1_val + head_e.imm;
  assign is_io     = head_addr[17:16] == IO_BASE[17:16];
  assign lsb_state = state;

  lsb_load_ext u_load_ext (
    .funct3 (head_e.funct3),
    .data   (mem_dout),
    .ext    (load_ext)
  );

  always_comb begin
    head_ready = 1'b0;
    if (head_e.store)
      head_ready = head_e.committed && head_e.rs1_rdy && head_e.rs2_rdy;
    else
      head_ready = head_e.rs1_rdy &&
                   (head_e.rob_id == rob_head_id || (SPEC_LOAD && !is_io));
  end

  // Memory handshake: a request (mem_req_en plus its attributes) is raised
  // from a register and held unchanged until the controller answers with a
  // single-cycle mem_done; that cycle completes the transfer and drops the
  // request, so the next one can start on the following cycle at the earliest.
  assign can_issue = head_e.valid && head_ready && !mem_req_en && !mem_done && !roll_back;
  assign pop       = (state != MEM_IDLE) && mem_done;
  assign push      = issue_en && !roll_back && (count != CNT_W'(LSB_SIZE) || pop);
  assign head_next = head + PTR_W'(pop);

  always_comb begin
    new_entry           = '0;
    new_entry.valid     = 1'b1;
    new_entry.store     = issue_store;
    new_entry.funct3    = issue_funct3;
    new_entry.rob_id    = issue_rob_id;
    new_entry.imm       = issue_imm;
    new_entry.rs1_tag   = issue_rs1_tag;
    new_entry.rs2_tag   = issue_rs2_tag;
    new_entry.rs1_rdy   = issue_rs1_rdy;
    new_entry.rs1_val   = issue_rs1_val;
    new_entry.rs2_rdy   = issue_rs2_rdy;
    new_entry.rs2_val   = issue_rs2_val;
    if (!issue_rs1_rdy && cdb_en && cdb_rob_id == issue_rs1_tag) begin
      new_entry.rs1_rdy = 1'b1;
      new_entry.rs1_val = cdb_val;
    end
    if (!issue_rs2_rdy && cdb_en && cdb_rob_id == issue_rs2_tag) begin
      new_entry.rs2_rdy = 1'b1;
      new_entry.rs2_val = cdb_val;
    end
  end

  // Committed stores always form a prefix of the queue, so rollback keeps
  // exactly that many entries starting at the (post-pop) head.
  always_comb begin
    committed_cnt = '0;
    for (int i = 0; i < LSB_SIZE; i++)
      if (entries[i].valid && entries[i].store && entries[i].committed)
        committed_cnt = committed_cnt + CNT_W'(1);
    if (pop && head_e.store && head_e.committed)
      committed_cnt = committed_cnt - CNT_W'(1);
  end

  always_comb begin
    if (roll_back) next_count = committed_cnt;
    else           next_count = count + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      state      <= MEM_IDLE;
      mem_req_en <= 1'b0;
      mem_rw     <= 1'b0;
      mem_width  <= 2'd0;
      mem_ain    <= '0;
      mem_din    <= '0;
      res_en     <= 1'b0;
      res_rob_id <= '0;
      res_val    <= '0;
      lsb_full   <= 1'b0;
      for (int i = 0; i < LSB_SIZE; i++) entries[i] <= '0;
    end else if (rdy_in) begin
      res_en <= 1'b0;
      for (int i = 0; i < LSB_SIZE; i++) begin
        if (entries[i].valid) begin
          if (!entries[i].rs1_rdy && cdb_en && entries[i].rs1_tag == cdb_rob_id) begin
            entries[i].rs1_rdy <= 1'b1;
            entries[i].rs1_val <= cdb_val;
          end
          if (!entries[i].rs2_rdy && cdb_en && entries[i].rs2_tag == cdb_rob_id) begin
            entries[i].rs2_rdy <= 1'b1;
            entries[i].rs2_val <= cdb_val;
          end
          if (commit_en && entries[i].rob_id == commit_rob_id)
            entries[i].committed <= 1'b1;
        end
      end

      if (pop) begin
        entries[head].valid <= 1'b0;
        head                <= head_next;
        state               <= MEM_IDLE;
        mem_req_en          <= 1'b0;
        if (state == MEM_LOAD && !roll_back) begin
          res_en     <= 1'b1;
          res_val    <= load_ext;
          res_rob_id <= head_e.rob_id;
        end
      end

      if (can_issue) begin
        state      <= head_e.store ? MEM_STORE : MEM_LOAD;
        mem_req_en <= 1'b1;
        mem_rw     <= head_e.store;
        mem_width  <= mem_width_of(head_e.funct3[1:0]);
        mem_ain    <= head_addr;
        mem_din    <= head_e.rs2_val;
      end

      if (roll_back) begin
        for (int i = 0; i < LSB_SIZE; i++)
          if (!(entries[i].store && entries[i].committed))
            entries[i].valid <= 1'b0;
        tail <= head_next + committed_cnt[PTR_W-1:0];
        // An in-flight load belongs to the squashed path; a store does not
        if (state == MEM_LOAD && !pop) begin
          state      <= MEM_IDLE;
          mem_req_en <= 1'b0;
        end
      end else if (push) begin
        entries[tail] <= new_entry;
        tail          <= tail + PTR_W'(1);
      end

      count    <= next_count;
      lsb_full <= next_count >= CNT_W'(LSB_SIZE - 1);
    end
  end

endmodule

// File: tb/tb_load_store_buffer.sv
// Directed self-checking bench for load_store_buffer (both LSB_SPEC_LOAD_EN builds).
module tb_load_store_buffer;
  import load_store_buffer_pkg::*;

  localparam int LSB_SIZE = 16;
  localparam int EW       = ROB_ID_W + 32;
`ifdef LSB_SPEC_LOAD_EN
  localparam logic SPEC = 1'b1;
`else
  localparam logic SPEC = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst_in, rdy_in, roll_back;
  logic                issue_en, issue_store;
  logic [2:0]          issue_funct3;
  logic [ROB_ID_W-1:0] issue_rob_id, issue_rs1_tag, issue_rs2_tag;
  logic [31:0]         issue_imm, issue_rs1_val, issue_rs2_val;
  logic                issue_rs1_rdy, issue_rs2_rdy;
  logic                cdb_en;
  logic [ROB_ID_W-1:0] cdb_rob_id, rob_head_id, commit_rob_id;
  logic [31:0]         cdb_val;
  logic                commit_en;
  logic                mem_req_en, mem_rw, mem_done;
  logic [1:0]          mem_width;
  logic [31:0]         mem_ain, mem_din, mem_dout;
  logic                res_en, lsb_full;
  logic [ROB_ID_W-1:0] res_rob_id;
  logic [31:0]         res_val;
  logic [1:0]          lsb_state;

  int n_checks = 0;
  int n_pass   = 0;
  logic [EW-1:0] exp_q[$];

  load_store_buffer #(.LSB_SIZE(LSB_SIZE)) dut (
    .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .roll_back(roll_back),
    .issue_en(issue_en), .issue_store(issue_store), .issue_funct3(issue_funct3),
    .issue_rob_id(issue_rob_id), .issue_imm(issue_imm),
    .issue_rs1_val(issue_rs1_val), .issue_rs2_val(issue_rs2_val),
    .issue_rs1_rdy(issue_rs1_rdy), .issue_rs2_rdy(issue_rs2_rdy),
    .issue_rs1_tag(issue_rs1_tag), .issue_rs2_tag(issue_rs2_tag),
    .cdb_en(cdb_en), .cdb_rob_id(cdb_rob_id), .cdb_val(cdb_val),
    .rob_head_id(rob_head_id), .commit_en(commit_en), .commit_rob_id(commit_rob_id),
    .mem_req_en(mem_req_en), .mem_rw(mem_rw), .mem_width(mem_width),
    .mem_ain(mem_ain), .mem_din(mem_din), .mem_done(mem_done), .mem_dout(mem_dout),
    .res_en(res_en), .res_rob_id(res_rob_id), .res_val(res_val),
    .lsb_full(lsb_full), .lsb_state(lsb_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst_in = 1'b0; rdy_in = 1'b1; roll_back = 1'b0;
    issue_en = 1'b0; issue_store = 1'b0; issue_funct3 = 3'd0; issue_rob_id = '0;
    issue_imm = '0; issue_rs1_val = '0; issue_rs2_val = '0;
    issue_rs1_rdy = 1'b0; issue_rs2_rdy = 1'b0; issue_rs1_tag = '0; issue_rs2_tag = '0;
    cdb_en = 1'b0; cdb_rob_id = '0; cdb_val = '0;
    rob_head_id = '0; commit_en = 1'b0; commit_rob_id = '0;
    mem_done = 1'b0; mem_dout = '0;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    tick();
    tick();
    rst_in = 1'b0;
  endtask

  task automatic dispatch(input logic st, input logic [2:0] f3, input logic [ROB_ID_W-1:0] rob,
                          input logic [31:0] rs1, input logic rs1_r, input logic [ROB_ID_W-1:0] t1,
                          input logic [31:0] imm, input logic [31:0] rs2, input logic rs2_r,
                          input logic [ROB_ID_W-1:0] t2);
    issue_en = 1'b1; issue_store = st; issue_funct3 = f3; issue_rob_id = rob;
    issue_rs1_val = rs1; issue_rs1_rdy = rs1_r; issue_rs1_tag = t1; issue_imm = imm;
    issue_rs2_val = rs2; issue_rs2_rdy = rs2_r; issue_rs2_tag = t2;
    tick();
    issue_en = 1'b0;
  endtask

  task automatic wait_req(input int budget, output logic seen);
    seen = mem_req_en;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      seen = mem_req_en;
    end
  endtask

  task automatic mem_complete(input logic [31:0] dout);
    mem_done = 1'b1;
    mem_dout = dout;
    tick();
    mem_done = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_in = 1'b1; rdy_in = 1'b0;
    tick();
    tick();
    n_checks++; if (mem_req_en !== 1'b0) $display("FAIL rst_req: got %b want 0", mem_req_en); else n_pass++;
    n_checks++; if (mem_rw !== 1'b0) $display("FAIL rst_rw: got %b want 0", mem_rw); else n_pass++;
    n_checks++; if (res_en !== 1'b0) $display("FAIL rst_res_en: got %b want 0", res_en); else n_pass++;
    n_checks++; if (lsb_full !== 1'b0) $display("FAIL rst_full: got %b want 0", lsb_full); else n_pass++;
    n_checks++; if (mem_ain !== 32'h0) $display("FAIL rst_ain: got %h want 0", mem_ain); else n_pass++;
    n_checks++; if (mem_din !== 32'h0) $display("FAIL rst_din: got %h want 0", mem_din); else n_pass++;
    n_checks++; if (res_val !== 32'h0) $display("FAIL rst_res_val: got %h want 0", res_val); else n_pass++;
    n_checks++; if (res_rob_id !== '0) $display("FAIL rst_res_rob: got %h want 0", res_rob_id); else n_pass++;
    n_checks++; if (lsb_state !== 2'd0) $display("FAIL rst_state: got %0d want 0", lsb_state); else n_pass++;
    rst_in = 1'b0; rdy_in = 1'b1;
    tick();
  endtask

  task automatic test_load_word();
    logic seen;
    rob_head_id = 4'd1;
    dispatch(1'b0, 3'b010, 4'd1, 32'h1000, 1'b1, 4'd0, 32'h4, 32'h0, 1'b1, 4'd0);
    wait_req(20, seen);
    n_checks++; if (seen !== 1'b1) $display("FAIL lw_req: got %b want 1", seen); else n_pass++;
    n_checks++; if (mem_ain !== 32'h1004) $display("FAIL lw_ain: got %h want 00001004", mem_ain); else n_pass++;
    n_checks++; if (mem_width !== 2'd3) $display("FAIL lw_width: got %0d want 3", mem_width); else n_pass++;
    n_checks++; if (mem_rw !== 1'b0) $display("FAIL lw_rw: got %b want 0", mem_rw); else n_pass++;
    mem_complete(32'hDEADBEEF);
    n_checks++; if (mem_req_en !== 1'b0) $display("FAIL lw_req_drop: got %b want 0", mem_req_en); else n_pass++;
    n_checks++; if (res_en !== 1'b1) $display("FAIL lw_res_en: got %b want 1", res_en); else n_pass++;
    n_checks++; if (res_val !== 32'hDEADBEEF) $display("FAIL lw_res_val: got %h want deadbeef", res_val); else n_pass++;
    n_checks++; if (res_rob_id !== 4'd1) $display("FAIL lw_res_rob: got %0d want 1", res_rob_id); else n_pass++;
    tick();
    n_checks++; if (res_en !== 1'b0) $display("FAIL lw_res_pulse: got %b want 0", res_en); else n_pass++;
  endtask

  task automatic test_load_ext();
    logic [2:0]  f3s  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] douts[4] = '{32'h80, 32'h80, 32'h8000, 32'h8000};
    logic [31:0] exps [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8000, 32'h00008000};
    logic [1:0]  wids [4] = '{2'd0, 2'd0, 2'd1, 2'd1};
    logic seen;
    for (int i = 0; i < 4; i++) begin
      rob_head_id = ROB_ID_W'(i + 2);
      dispatch(1'b0, f3s[i], ROB_ID_W'(i + 2), 32'h2000, 1'b1, 4'd0, 32'h1, 32'h0, 1'b1, 4'd0);
      wait_req(20, seen);
      n_checks++; if (seen !== 1'b1) $display("FAIL ext_req[%0d]: got %b want 1", i, seen); else n_pass++;
      n_checks++; if (mem_ain !== 32'h2001) $display("FAIL ext_ain[%0d]: got %h want 00002001", i, mem_ain); else n_pass++;
      n_checks++; if (mem_width !== wids[i]) $display("FAIL ext_width[%0d]: got %0d want %0d", i, mem_width, wids[i]); else n_pass++;
      mem_complete(douts[i]);
      n_checks++; if (res_val !== exps[i]) $display("FAIL ext_val[%0d]: got %h want %h", i, res_val, exps[i]); else n_pass++;
    end
  endtask

  task automatic test_cdb_on_dispatch();
    logic seen;
    rob_head_id = 4'd7;
    cdb_en = 1'b1; cdb_rob_id = 4'd12; cdb_val = 32'h600;
    dispatch(1'b0, 3'b010, 4'd7, 32'h0, 1'b0, 4'd12, 32'h20, 32'h0, 1'b1, 4'd0);
    cdb_en = 1'b0;
    wait_req(20, seen);
    n_checks++; if (seen !== 1'b1) $display("FAIL cdb_disp_req: got %b want 1", seen); else n_pass++;
    n_checks++; if (mem_ain !== 32'h620) $display("FAIL cdb_disp_ain: got %h want 00000620", mem_ain); else n_pass++;
    mem_complete(32'h0);
  endtask

  task automatic test_store_commit();
    logic seen;
    rob_head_id = 4'd0;
    dispatch(1'b1, 3'b010, 4'd5, 32'h3000, 1'b1, 4'd0, 32'h8, 32'h0, 1'b0, 4'd3);
    wait_req(4, seen);
    n_checks++; if (seen !== 1'b0) $display("FAIL sw_wait_operand: got %b want 0", seen); else n_pass++;
    cdb_en = 1'b1; cdb_rob_id = 4'd3; cdb_val = 32'h55;
    tick();
    cdb_en = 1'b0;
    wait_req(4, seen);
    n_checks++; if (seen !== 1'b0) $display("FAIL sw_wait_commit: got %b want 0", seen); else n_pass++;
    commit_en = 1'b1; commit_rob_id = 4'd5;
    tick();
    commit_en = 1'b0;
    wait_req(20, seen);
    n_checks++; if (seen !== 1'b1) $display("FAIL sw_req: got %b want 1", seen); else n_pass++;
    n_checks++; if (mem_rw !== 1'b1) $display("FAIL sw_rw: got %b want 1", mem_rw); else n_pass++;
    n_checks++; if (mem_din !== 32'h55) $display("FAIL sw_din: got %h want 00000055", mem_din); else n_pass++;
    n_checks++; if (mem_ain !== 32'h3008) $display("FAIL sw_ain: got %h want 00003008", mem_ain); else n_pass++;
    mem_complete(32'h0);
    n_checks++; if (res_en !== 1'b0) $display("FAIL sw_no_res: got %b want 0", res_en); else n_pass++;
    n_checks++; if (mem_req_en !== 1'b0) $display("FAIL sw_req_drop: got %b want 0", mem_req_en); else n_pass++;
    tick();
    n_checks++; if (res_en !== 1'b0) $display("FAIL sw_no_res_late: got %b want 0", res_en); else n_pass++;
  endtask

  task automatic test_rdy_stall();
    logic seen;
    rob_head_id = 4'd6;
    dispatch(1'b0, 3'b010, 4'd6, 32'h100, 1'b1, 4'd0, 32'h0, 32'h0, 1'b1, 4'd0);
    wait_req(20, seen);
    n_checks++; if (seen !== 1'b1) $display("FAIL stall_req: got %b want 1", seen); else n_pass++;
    rdy_in = 1'b0; mem_done = 1'b1; mem_dout = 32'hCAFE0001;
    tick();
    n_checks++; if (res_en !== 1'b0) $display("FAIL stall_no_res: got %b want 0", res_en); else n_pass++;
    n_checks++; if (mem_req_en !== 1'b1) $display("FAIL stall_req_held: got %b want 1", mem_req_en); else n_pass++;
    rdy_in = 1'b1;
    tick();
    mem_done = 1'b0;
    n_checks++; if (res_en !== 1'b1) $display("FAIL stall_res_en: got %b want 1", res_en); else n_pass++;
    n_checks++; if (res_val !== 32'hCAFE0001) $display("FAIL stall_res_val: got %h want cafe0001", res_val); else n_pass++;
  endtask

  // Retires every entry in exp_q in order, making each one the ROB head in turn
  task automatic drain_queue();
    logic [EW-1:0]       e;
    logic [ROB_ID_W-1:0] rob;
    logic [31:0]         addr;
    logic                seen;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      rob = e[EW-1:32];
      addr = e[31:0];
      rob_head_id = rob;
      wait_req(20, seen);
      n_checks++; if (seen !== 1'b1) $display("FAIL drain_req rob %0d: got %b want 1", rob, seen); else n_pass++;
      n_checks++; if (mem_ain !== addr) $display("FAIL drain_order rob %0d: got %h want %h", rob, mem_ain, addr); else n_pass++;
      mem_complete(addr ^ 32'h5A5A0F0F);
      n_checks++; if (res_val !== (addr ^ 32'h5A5A0F0F)) $display("FAIL drain_val rob %0d: got %h want %h", rob, res_val, addr ^ 32'h5A5A0F0F); else n_pass++;
      n_checks++; if (res_rob_id !== rob) $display("FAIL drain_rob: got %0d want %0d", res_rob_id, rob); else n_pass++;
    end
  endtask

  task automatic test_full_and_wrap();
    logic [ROB_ID_W-1:0] rob;
    logic [31:0]         addr;
    do_reset();
    rob_head_id = 4'd15;
    for (int i = 0; i < LSB_SIZE - 1; i++) begin
      rob = ROB_ID_W'(i);
      addr = 32'h30000 + 32'(4 * i);
      dispatch(1'b0, 3'b010, rob, 32'h30000, 1'b1, 4'd0, 32'(4 * i), 32'h0, 1'b1, 4'd0);
      exp_q.push_back({rob, addr});
      if (i == LSB_SIZE - 3) begin
        n_checks++; if (lsb_full !== 1'b0) $display("FAIL full_at_14: got %b want 0", lsb_full); else n_pass++;
      end
    end
    n_checks++; if (lsb_full !== 1'b1) $display("FAIL full_at_15: got %b want 1", lsb_full); else n_pass++;
    n_checks++; if (mem_req_en !== 1'b0) $display("FAIL full_no_issue: got %b want 0", mem_req_en); else n_pass++;
    begin
      logic [EW-1:0] e;
      logic          seen;
      e = exp_q.pop_front();
      rob_head_id = e[EW-1:32];
      wait_req(20, seen);
      n_checks++; if (mem_ain !== e[31:0]) $display("FAIL full_first_ain: got %h want %h", mem_ain, e[31:0]); else n_pass++;
      mem_complete(32'h0);
      n_checks++; if (lsb_full !== 1'b0) $display("FAIL full_after_pop: got %b want 0", lsb_full); else n_pass++;
    end
    drain_queue();
    for (int b = 0; b < 8; b++) begin
      rob_head_id = ROB_ID_W'(b * 4 + 8);
      for (int j = 0; j < 4; j++) begin
        rob = ROB_ID_W'(b * 4 + j);
        addr = 32'h30100 + 32'(4 * (b * 4 + j));
        dispatch(1'b0, 3'b010, rob, 32'h30100, 1'b1, 4'd0, 32'(4 * (b * 4 + j)), 32'h0, 1'b1, 4'd0);
        exp_q.push_back({rob, addr});
      end
      drain_queue();
    end
  endtask

  task automatic test_rollback();
    logic seen;
    do_reset();
    rob_head_id = 4'd9;
    dispatch(1'b1, 3'b010, 4'd1, 32'h4000, 1'b1, 4'd0, 32'h0, 32'h77, 1'b1, 4'd0);
    dispatch(1'b0, 3'b010, 4'd2, 32'h30000, 1'b1, 4'd0, 32'h10, 32'h0, 1'b1, 4'd0);
    dispatch(1'b0, 3'b010, 4'd3, 32'h30000, 1'b1, 4'd0, 32'h20, 32'h0, 1'b1, 4'd0);
    commit_en = 1'b1; commit_rob_id = 4'd1;
    tick();
    commit_en = 1'b0;
    wait_req(20, seen);
    n_checks++; if (seen !== 1'b1) $display("FAIL rb_store_req: got %b want 1", seen); else n_pass++;
    n_checks++; if (mem_rw !== 1'b1) $display("FAIL rb_store_rw: got %b want 1", mem_rw); else n_pass++;
    roll_back = 1'b1;
    tick();
    roll_back = 1'b0;
    n_checks++; if (mem_req_en !== 1'b1) $display("FAIL rb_store_kept: got %b want 1", mem_req_en); else n_pass++;
    n_checks++; if (mem_din !== 32'h77) $display("FAIL rb_store_din: got %h want 00000077", mem_din); else n_pass++;
    rob_head_id = 4'd2;
    mem_complete(32'h0);
    n_checks++; if (res_en !== 1'b0) $display("FAIL rb_store_no_res: got %b want 0", res_en); else n_pass++;
    wait_req(5, seen);
    n_checks++; if (seen !== 1'b0) $display("FAIL rb_squashed_issue: got %b want 0", seen); else n_pass++;
    rob_head_id = 4'd4;
    dispatch(1'b0, 3'b010, 4'd4, 32'h5000, 1'b1, 4'd0, 32'h0, 32'h0, 1'b1, 4'd0);
    wait_req(20, seen);
    n_checks++; if (mem_ain !== 32'h5000) $display("FAIL rb_next_ain: got %h want 00005000", mem_ain); else n_pass++;
    mem_complete(32'h0);
    n_checks++; if (res_rob_id !== 4'd4) $display("FAIL rb_next_rob: got %0d want 4", res_rob_id); else n_pass++;
    // Queue must be empty now: exactly 15 new entries reach the full mark
    rob_head_id = 4'd15;
    for (int i = 0; i < LSB_SIZE - 2; i++)
      dispatch(1'b0, 3'b010, ROB_ID_W'(i), 32'h30000, 1'b1, 4'd0, 32'h0, 32'h0, 1'b1, 4'd0);
    n_checks++; if (lsb_full !== 1'b0) $display("FAIL rb_count_14: got %b want 0", lsb_full); else n_pass++;
    dispatch(1'b0, 3'b010, 4'd14, 32'h30000, 1'b1, 4'd0, 32'h0, 32'h0, 1'b1, 4'd0);
    n_checks++; if (lsb_full !== 1'b1) $display("FAIL rb_count_15: got %b want 1", lsb_full); else n_pass++;
    do_reset();
  endtask

  task automatic test_speculation();
    logic seen;
    do_reset();
    rob_head_id = 4'd9;
    dispatch(1'b0, 3'b010, 4'd3, 32'h30000, 1'b1, 4'd0, 32'h4, 32'h0, 1'b1, 4'd0);
    wait_req(6, seen);
    n_checks++; if (seen !== 1'b0) $display("FAIL spec_io_wait: got %b want 0", seen); else n_pass++;
    do_reset();
    dispatch(1'b0, 3'b010, 4'd4, 32'h2000, 1'b1, 4'd0, 32'h0, 32'h0, 1'b1, 4'd0);
    wait_req(6, seen);
    n_checks++; if (seen !== SPEC) $display("FAIL spec_mem_issue: got %b want %b", seen, SPEC); else n_pass++;
    if (!seen) begin
      rob_head_id = 4'd4;
      wait_req(20, seen);
      n_checks++; if (seen !== 1'b1) $display("FAIL spec_head_issue: got %b want 1", seen); else n_pass++;
    end
    n_checks++; if (mem_ain !== 32'h2000) $display("FAIL spec_ain: got %h want 00002000", mem_ain); else n_pass++;
    mem_complete(32'h1111);
    n_checks++; if (res_val !== 32'h1111) $display("FAIL spec_res_val: got %h want 00001111", res_val); else n_pass++;
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_load_word();
    test_load_ext();
    test_cdb_on_dispatch();
    test_store_commit();
    test_rdy_stall();
    test_full_and_wrap();
    test_rollback();
    test_speculation();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
